// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, FSM states, IR field positions and output decode for cpu_control
//
// Shared by cpu_control and pc_unit.
//   OP_*          : 2-bit opcode values held in IR[7:6]
//   state_t       : control FSM states FETCH, DECODE, EXEC, WB, HALT
//   *_HI / *_LO   : IR field bit positions
//   ctrl_t        : bundle of the registered control outputs
//   ctrl_decode() : Moore output function of (state, IR)
package cpu_ctrl_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_LI   = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int OPC_HI     = 7;
    localparam int OPC_LO     = 6;
    localparam int ADD_RS_HI  = 5;
    localparam int ADD_RS_LO  = 4;
    localparam int ADD_RT_HI  = 3;
    localparam int ADD_RT_LO  = 2;
    localparam int ADD_RD_HI  = 1;
    localparam int ADD_RD_LO  = 0;
    localparam int LI_RD_HI   = 5;
    localparam int LI_RD_LO   = 4;
    localparam int LI_IMM_HI  = 3;
    localparam int LI_IMM_LO  = 0;
    localparam int JMP_OFF_HI = 5;
    localparam int JMP_OFF_LO = 0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    typedef struct packed {
        logic       alu_op;
        logic       reg_write;
        logic       imm_sel;
        logic       halted;
        logic [1:0] read_reg1;
        logic [1:0] read_reg2;
        logic [1:0] write_reg;
        logic [7:0] imm;
    } ctrl_t;

    // Control outputs as a pure function of the FSM state and IR.
    // Register addresses and the immediate are presented from DECODE
    // through WB; the ALU/immediate selects only in EXEC and WB.
    function automatic ctrl_t ctrl_decode(input state_t s, input logic [7:0] ir);
        ctrl_t      c;
        logic [1:0] op;
        logic       active;
        logic       exec_wb;
        c       = '0;
        op      = ir[OPC_HI:OPC_LO];
        active  = (s == S_DECODE) || (s == S_EXEC) || (s == S_WB);
        exec_wb = (s == S_EXEC) || (s == S_WB);
        if (active) begin
            case (op)
                OP_ADD: begin
                    c.read_reg1 = ir[ADD_RS_HI:ADD_RS_LO];
                    c.read_reg2 = ir[ADD_RT_HI:ADD_RT_LO];
                    c.write_reg = ir[ADD_RD_HI:ADD_RD_LO];
                end
                OP_LI: begin
                    c.write_reg = ir[LI_RD_HI:LI_RD_LO];
                    c.imm       = {{4{ir[LI_IMM_HI]}}, ir[LI_IMM_HI:LI_IMM_LO]};
                end
                default: ;
            endcase
        end
        c.alu_op    = exec_wb && (op == OP_ADD);
        c.imm_sel   = exec_wb && (op == OP_LI);
        // WB is only ever entered by ADD and LI.
        c.reg_write = (s == S_WB);
        c.halted    = (s == S_HALT);
        return c;
    endfunction

endpackage

// File: rtl/cpu_control_pc_unit.sv
// rtl/cpu_control_pc_unit.sv - program counter register for cpu_control
//
// Ports:
//   i_clk, i_clear : clock, asynchronous active-high reset (loads PC_RESET)
//   i_inc          : PC <= PC + 1 (wraps modulo 2^PC_W)
//   i_jmp          : PC <= PC + sext(i_off) (modulo 2^PC_W); wins over i_inc
//   i_off          : signed 6-bit relative jump offset
//   o_pc           : current program counter
module pc_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] PC_RESET = 8'h00
) (
    input  logic            i_clk,
    input  logic            i_clear,
    input  logic            i_inc,
    input  logic            i_jmp,
    input  logic [5:0]      i_off,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_off_ext;

    assign w_off_ext = {{(PC_W-6){i_off[5]}}, i_off};

    // Plain PC_W-bit addition gives the modulo wrap for both paths.
    always_ff @(posedge i_clk or posedge i_clear) begin
        if (i_clear) begin
            r_pc <= PC_RESET;
        end else if (i_jmp) begin
            r_pc <= r_pc + w_off_ext;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - multi-cycle control unit: FETCH/DECODE/EXEC/WB/HALT FSM, IR and output decode
//
// Optional feature macro: CPU_CTRL_SINGLE_STEP_EN (adds Step input gating FETCH).
// Ports:
//   Clk, Clear          : clock, asynchronous active-high reset
//   Step                : (CPU_CTRL_SINGLE_STEP_EN only) fetch enable, one instruction per pulse
//   Instr, InstrValid   : instruction word at PC and its valid flag
//   PC                  : program counter
//   ALUOp, RegWrite     : ALU add enable, register-file write strobe
//   ReadReg1/2,WriteReg : register-file addresses
//   ImmSel, Imm         : write-back immediate select, sign-extended immediate
//   Halted              : high in HALT
module cpu_control
    import cpu_ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] PC_RESET = 8'h00
) (
    input  logic            Clk,
    input  logic            Clear,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic            Step,
`endif
    input  logic [7:0]      Instr,
    input  logic            InstrValid,
    output logic [PC_W-1:0] PC,
    output logic            ALUOp,
    output logic            RegWrite,
    output logic [1:0]      ReadReg1,
    output logic [1:0]      ReadReg2,
    output logic [1:0]      WriteReg,
    output logic            ImmSel,
    output logic [7:0]      Imm,
    output logic            Halted
);

    state_t     r_state;
    logic [7:0] r_ir;
    ctrl_t      r_ctrl;

    logic       w_fetch;
    logic [1:0] w_op;
    logic       w_pc_inc;
    logic       w_pc_jmp;

`ifdef CPU_CTRL_SINGLE_STEP_EN
    assign w_fetch = InstrValid & Step;
`else
    assign w_fetch = InstrValid;
`endif

    assign w_op     = r_ir[OPC_HI:OPC_LO];
    assign w_pc_inc = (r_state == S_WB);
    assign w_pc_jmp = (r_state == S_EXEC) && (w_op == OP_JMP);

    // Outputs are registered alongside the state: every transition loads
    // ctrl_decode(next_state, next_ir), so r_ctrl always equals the Moore
    // decode of the current (r_state, r_ir).
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_state <= S_FETCH;
            r_ir    <= 8'h00;
            r_ctrl  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_fetch) begin
                        r_ir    <= Instr;
                        r_state <= S_DECODE;
                        r_ctrl  <= ctrl_decode(S_DECODE, Instr);
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                    r_ctrl  <= ctrl_decode(S_EXEC, r_ir);
                end
                S_EXEC: begin
                    case (w_op)
                        OP_ADD, OP_LI: begin
                            r_state <= S_WB;
                            r_ctrl  <= ctrl_decode(S_WB, r_ir);
                        end
                        OP_JMP: begin
                            r_state <= S_FETCH;
                            r_ctrl  <= ctrl_decode(S_FETCH, r_ir);
                        end
                        default: begin
                            r_state <= S_HALT;
                            r_ctrl  <= ctrl_decode(S_HALT, r_ir);
                        end
                    endcase
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_ctrl  <= ctrl_decode(S_FETCH, r_ir);
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                    r_ctrl  <= '0;
                end
            endcase
        end
    end

    pc_unit #(
        .PC_W     (PC_W),
        .PC_RESET (PC_RESET)
    ) u_pc_unit (
        .i_clk   (Clk),
        .i_clear (Clear),
        .i_inc   (w_pc_inc),
        .i_jmp   (w_pc_jmp),
        .i_off   (r_ir[JMP_OFF_HI:JMP_OFF_LO]),
        .o_pc    (PC)
    );

    assign ALUOp    = r_ctrl.alu_op;
    assign RegWrite = r_ctrl.reg_write;
    assign ImmSel   = r_ctrl.imm_sel;
    assign Halted   = r_ctrl.halted;
    assign ReadReg1 = r_ctrl.read_reg1;
    assign ReadReg2 = r_ctrl.read_reg2;
    assign WriteReg = r_ctrl.write_reg;
    assign Imm      = r_ctrl.imm;

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - self-checking bench for cpu_control against an instruction-level model
module tb_cpu_control;

    logic       Clk = 1'b0;
    logic       Clear = 1'b1;
    logic [7:0] Instr = 8'h00;
    logic       InstrValid = 1'b0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    logic       Step = 1'b0;
`endif
    logic [7:0] PC;
    logic       ALUOp, RegWrite, ImmSel, Halted;
    logic [1:0] ReadReg1, ReadReg2, WriteReg;
    logic [7:0] Imm;

    int n_cmp  = 0;
    int n_fail = 0;
    int ref_pc = 0;

    cpu_control #(.PC_W(8), .PC_RESET(8'h00)) dut (
        .Clk        (Clk),
        .Clear      (Clear),
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .Step       (Step),
`endif
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
        .ALUOp      (ALUOp),
        .RegWrite   (RegWrite),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .WriteReg   (WriteReg),
        .ImmSel     (ImmSel),
        .Imm        (Imm),
        .Halted     (Halted)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Instruction-level model: executes one instruction from the FETCH
    // negedge and checks every phase of it. Leaves the bench at the next
    // FETCH negedge (or at the HALT negedge).
    task automatic exec_instr(input logic [7:0] ins);
        int         op, v, off, exp_pc;
        logic [1:0] e_rr1, e_rr2, e_wr;
        logic [7:0] e_imm;
        logic       e_alu, e_isel;
        op = int'(ins[7:6]);
        e_rr1 = 2'd0; e_rr2 = 2'd0; e_wr = 2'd0; e_imm = 8'h00;
        e_alu = (op == 0); e_isel = (op == 1);
        exp_pc = ref_pc;
        if (op == 0) begin
            e_rr1 = ins[5:4]; e_rr2 = ins[3:2]; e_wr = ins[1:0];
            exp_pc = (ref_pc + 1) % 256;
        end else if (op == 1) begin
            e_wr = ins[5:4];
            v = int'(ins[3:0]);
            if (v >= 8) v = v - 16;
            e_imm = 8'(v);
            exp_pc = (ref_pc + 1) % 256;
        end else if (op == 2) begin
            off = int'(ins[5:0]);
            if (off >= 32) off = off - 64;
            exp_pc = (ref_pc + off + 256) % 256;
        end

        Instr = ins; InstrValid = 1'b1;
`ifdef CPU_CTRL_SINGLE_STEP_EN
        Step = 1'b1;
`endif
        @(posedge Clk); #1;
        // junk on the inputs outside FETCH must not matter
        Instr = 8'($urandom); InstrValid = 1'($urandom);
`ifdef CPU_CTRL_SINGLE_STEP_EN
        Step = 1'($urandom);
`endif
        @(negedge Clk);
        n_cmp++;
        if ({ReadReg1, ReadReg2, WriteReg, ALUOp, ImmSel, RegWrite} !== {e_rr1, e_rr2, e_wr, 3'b000}) begin
            n_fail++;
            $display("FAIL decode ins=%h: got rr1/rr2/wr/alu/isel/rw=%0d/%0d/%0d/%b%b%b need %0d/%0d/%0d/000",
                     ins, ReadReg1, ReadReg2, WriteReg, ALUOp, ImmSel, RegWrite, e_rr1, e_rr2, e_wr);
        end
        @(negedge Clk);
        n_cmp++;
        if ({ALUOp, ImmSel, Imm, RegWrite, Halted, WriteReg, PC} !== {e_alu, e_isel, e_imm, 2'b00, e_wr, 8'(ref_pc)}) begin
            n_fail++;
            $display("FAIL exec ins=%h: got alu=%b isel=%b imm=%h rw=%b h=%b wr=%0d pc=%h need %b %b %h 0 0 %0d %h",
                     ins, ALUOp, ImmSel, Imm, RegWrite, Halted, WriteReg, PC, e_alu, e_isel, e_imm, e_wr, 8'(ref_pc));
        end
        if (op == 3) begin
            @(negedge Clk);
            n_cmp++;
            if ({Halted, RegWrite, ALUOp, ImmSel, PC} !== {4'b1000, 8'(ref_pc)}) begin
                n_fail++;
                $display("FAIL halt_entry: got h/rw/alu/isel=%b%b%b%b pc=%h need 1000 pc=%h",
                         Halted, RegWrite, ALUOp, ImmSel, PC, 8'(ref_pc));
            end
        end else begin
            if (op != 2) begin
                @(negedge Clk);
                n_cmp++;
                if ({RegWrite, ALUOp, ImmSel, Imm, WriteReg, PC} !== {1'b1, e_alu, e_isel, e_imm, e_wr, 8'(ref_pc)}) begin
                    n_fail++;
                    $display("FAIL wb ins=%h: got rw=%b alu=%b isel=%b imm=%h wr=%0d pc=%h need 1 %b %b %h %0d %h",
                             ins, RegWrite, ALUOp, ImmSel, Imm, WriteReg, PC, e_alu, e_isel, e_imm, e_wr, 8'(ref_pc));
                end
            end
            @(negedge Clk);
            n_cmp++;
            if ({RegWrite, ALUOp, ImmSel, Halted, PC} !== {4'b0000, 8'(exp_pc)}) begin
                n_fail++;
                $display("FAIL next_fetch ins=%h: got rw/alu/isel/h=%b%b%b%b pc=%h need 0000 pc=%h",
                         ins, RegWrite, ALUOp, ImmSel, Halted, PC, 8'(exp_pc));
            end
        end
        ref_pc = exp_pc;
        InstrValid = 1'b0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
        Step = 1'b0;
`endif
    endtask

    task automatic test_reset;
        Clear = 1'b1; InstrValid = 1'b1; Instr = 8'h1B;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if ({PC, ALUOp, RegWrite, ImmSel, Halted, ReadReg1, ReadReg2, WriteReg, Imm} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h alu=%b rw=%b isel=%b h=%b rr=%0d/%0d/%0d imm=%h need all zero",
                     PC, ALUOp, RegWrite, ImmSel, Halted, ReadReg1, ReadReg2, WriteReg, Imm);
        end
        InstrValid = 1'b0;
        Clear = 1'b0;
        ref_pc = 0;
    endtask

    task automatic test_directed;
        exec_instr(8'b00_01_10_11);
        n_cmp++;
        if (PC !== 8'h01) begin n_fail++; $display("FAIL add_pc: got %h need 01", PC); end
        exec_instr(8'b01_10_1110);
        exec_instr(8'b10_000011);
        n_cmp++;
        if (PC !== 8'h05) begin n_fail++; $display("FAIL jmp_fwd: got %h need 05", PC); end
        exec_instr(8'b10_111101);
        n_cmp++;
        if (PC !== 8'h02) begin n_fail++; $display("FAIL jmp_back: got %h need 02", PC); end
        exec_instr(8'b10_111101);
        n_cmp++;
        if (PC !== 8'hFF) begin n_fail++; $display("FAIL jmp_wrap: got %h need ff", PC); end
        exec_instr(8'b00_11_00_01);
        n_cmp++;
        if (PC !== 8'h00) begin n_fail++; $display("FAIL inc_wrap: got %h need 00", PC); end
    endtask

    task automatic test_stall;
        InstrValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            Instr = 8'($urandom);
            @(negedge Clk);
            n_cmp++;
            if ({PC, ReadReg1, ReadReg2, WriteReg, RegWrite, ALUOp} !== {8'(ref_pc), 8'h00}) begin
                n_fail++;
                $display("FAIL stall cycle %0d: got pc=%h rr=%0d/%0d/%0d rw=%b alu=%b need pc=%h idle",
                         i, PC, ReadReg1, ReadReg2, WriteReg, RegWrite, ALUOp, 8'(ref_pc));
            end
        end
        exec_instr({2'b00, 6'($urandom)});
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            exec_instr({2'($urandom_range(0, 2)), 6'($urandom)});
        end
    endtask

    task automatic test_halt;
        exec_instr({2'b11, 6'($urandom)});
        for (int i = 0; i < 10; i++) begin
            Instr = 8'($urandom); InstrValid = 1'b1;
            @(negedge Clk);
            n_cmp++;
            if ({Halted, RegWrite, ALUOp, ImmSel, PC} !== {4'b1000, 8'(ref_pc)}) begin
                n_fail++;
                $display("FAIL halt_hold %0d: got h/rw/alu/isel=%b%b%b%b pc=%h need 1000 pc=%h",
                         i, Halted, RegWrite, ALUOp, ImmSel, PC, 8'(ref_pc));
            end
        end
        InstrValid = 1'b0;
        #2 Clear = 1'b1;
        #1;
        n_cmp++;
        if ({Halted, PC} !== 9'd0) begin
            n_fail++;
            $display("FAIL halt_clear: got h=%b pc=%h need 0 00", Halted, PC);
        end
        @(negedge Clk);
        Clear = 1'b0;
        ref_pc = 0;
        exec_instr(8'b01_01_0011);
    endtask

    task automatic test_clear_wb;
        exec_instr(8'b10_000111);
        Instr = 8'b00_10_01_11; InstrValid = 1'b1;
        @(posedge Clk); #1;
        InstrValid = 1'b0;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL clear_wb_pre: got rw=%b need 1", RegWrite); end
        #2 Clear = 1'b1;
        #1;
        n_cmp++;
        if ({RegWrite, ALUOp, WriteReg, PC} !== 12'd0) begin
            n_fail++;
            $display("FAIL clear_wb: got rw=%b alu=%b wr=%0d pc=%h need 0 0 0 00", RegWrite, ALUOp, WriteReg, PC);
        end
        @(negedge Clk);
        Clear = 1'b0;
        ref_pc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_cmp++;
            if ({RegWrite, PC} !== 9'd0) begin
                n_fail++;
                $display("FAIL clear_wb_after %0d: got rw=%b pc=%h need 0 00", i, RegWrite, PC);
            end
        end
        exec_instr(8'b00_00_01_10);
    endtask

`ifdef CPU_CTRL_SINGLE_STEP_EN
    task automatic test_single_step;
        Instr = 8'b00_01_10_11; InstrValid = 1'b1; Step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            n_cmp++;
            if ({PC, ReadReg1, WriteReg} !== {8'(ref_pc), 4'd0}) begin
                n_fail++;
                $display("FAIL step_hold %0d: got pc=%h rr1=%0d wr=%0d need pc=%h idle", i, PC, ReadReg1, WriteReg, 8'(ref_pc));
            end
        end
        exec_instr(8'b00_01_10_11);
        Instr = 8'b01_11_0101; InstrValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            n_cmp++;
            if ({PC, WriteReg} !== {8'(ref_pc), 2'd0}) begin
                n_fail++;
                $display("FAIL step_once %0d: got pc=%h wr=%0d need pc=%h idle", i, PC, WriteReg, 8'(ref_pc));
            end
        end
        InstrValid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_halt();
        test_clear_wb();
`ifdef CPU_CTRL_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 Parameter: PC_RESET, 8'h00, PC value loaded on reset.
REQ-002 Parameter: PC_W, 8, program-counter width in bits.
REQ-003 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: Clear  input  1  asynchronous, active-high reset.
REQ-005 Port: Instr  input  8  instruction word from instruction memory at address PC.
REQ-006 Port: InstrValid  input  1  Instr valid this cycle.
REQ-007 Port: PC  output  PC_W  current program counter.
REQ-008 Port: ALUOp  output  1  enables the ALU add (ALU outputs 0 when low).
REQ-009 Port: RegWrite  output  1  register-file write strobe.
REQ-010 Port: ReadReg1, ReadReg2, WriteReg  output  2 each  register-file addresses.
REQ-011 Port: ImmSel  output  1  write-back selects Imm instead of ALU result.
REQ-012 Port: Imm  output  8  sign-extended immediate.
REQ-013 Port: Halted  output  1  high while in HALT.

Function
REQ-014 Instr encoding: [7:6] opcode; 00 ADD (rs=[5:4], rt=[3:2], rd=[1:0]); 01 LI (rd=[5:4], imm4=[3:0]); 10 JMP (signed off6=[5:0]); 11 HALT.
REQ-015 FSM states SHALL be FETCH, DECODE, EXEC, WB, HALT.
REQ-016 FETCH: IR <= Instr and go to DECODE only when InstrValid=1; otherwise stay, PC unchanged.
REQ-017 DECODE -> EXEC unconditionally; ReadReg1/ReadReg2/WriteReg driven from IR fields from DECODE through WB.
REQ-018 EXEC: ADD/LI -> WB; JMP -> PC <= PC + sext(off6) (modulo 2^PC_W), go to FETCH, no write; HALT -> HALT.
REQ-019 WB: RegWrite=1 for exactly one cycle; PC <= PC+1 with wrap (8'hFF -> 8'h00); go to FETCH.
REQ-020 ALUOp=1 in EXEC and WB for ADD only; 0 in every other state/opcode.
REQ-021 ImmSel=1 in EXEC and WB for LI only; Imm = sext(imm4) for LI, 0 otherwise.
REQ-022 HALT: absorbing; all strobes 0, Halted=1, PC frozen, InstrValid ignored; exit only by Clear.
REQ-023 Control outputs SHALL be Moore (decoded from state and IR only, never from Instr directly).
REQ-024 ADD/LI: 4 cycles from accepted fetch to next FETCH; JMP: 3 cycles.

Reset
REQ-025 Clear=1 asynchronously forces state=FETCH, PC=PC_RESET, IR=8'h00, all outputs 0, Halted=0.
REQ-026 Clear asserted mid-instruction (any state, incl. WB) SHALL abort it; no RegWrite pulse is produced.
REQ-027 After Clear deasserts, first fetch is accepted at the first rising edge with InstrValid=1.

Configuration
REQ-028 Macro CPU_CTRL_SINGLE_STEP_EN: when defined, adds input port Step (1 bit); FETCH advances only when InstrValid=1 and Step=1 in the same cycle, one instruction per Step pulse.
REQ-029 Without CPU_CTRL_SINGLE_STEP_EN: no Step port; FETCH advances on InstrValid alone.

Structure
REQ-030 Package cpu_ctrl_pkg SHALL hold opcode constants (OP_ADD, OP_LI, OP_JMP, OP_HALT), the FSM state typedef/encoding and field bit-position constants.
REQ-031 Sub-module pc_unit SHALL own the PC register: reset load, increment-with-wrap, signed relative add.
REQ-032 FSM, IR and output decode SHALL reside in cpu_control.

Verification
REQ-033 Reset then Instr=8'b00_01_10_11 valid -> ReadReg1=1, ReadReg2=2, WriteReg=3, ALUOp=1 in EXEC/WB, single RegWrite pulse, PC 00->01.
REQ-034 LI Instr=8'b01_10_1110 -> Imm=8'hFE, ImmSel=1, WriteReg=2, RegWrite one cycle, ALUOp=0.
REQ-035 PC=8'h05, JMP off6=6'b111101 -> PC=8'h02, no RegWrite; PC=8'hFF after ADD -> PC=8'h00.
REQ-036 InstrValid held low 10 cycles in FETCH -> state and PC unchanged; HALT opcode -> Halted=1 and frozen until Clear.
REQ-037 Clear pulsed during WB -> RegWrite deasserts immediately, PC=PC_RESET, state FETCH.
REQ-038 With CPU_CTRL_SINGLE_STEP_EN: InstrValid=1, Step=0 -> no fetch; one Step pulse -> exactly one instruction executes.
